// File: rtl/fir_frame_buffer_if.sv
// Bus bundle between the FIR sample stream, the frame buffer and the FFT frame sink.
//
// Handshake rules:
//   fir_valid/fir_d : push-only stream. One sample per high cycle. There is no
//                     backpressure, so the sink either stores the sample or drops it.
//   frm_valid/frm_ready : a frame moves on a rising edge where both are high.
//                     While frm_valid=1 and frm_ready=0, frm_data and frm_bank hold
//                     stable. frm_ready while frm_valid=0 has no effect.
interface fir_frame_buffer_if #(
    parameter int N  = 16,
    parameter int DW = 16
);
    logic            fir_valid;
    logic [DW-1:0]   fir_d;
    logic            frm_ready;
    logic            frm_valid;
    logic [N*DW-1:0] frm_data;
    logic            frm_bank;
    logic            ovf;

    // Frame buffer side
    modport slave (
        input  fir_valid, fir_d, frm_ready,
        output frm_valid, frm_data, frm_bank, ovf
    );

    // Environment side: drives the sample stream and takes frames
    modport master (
        output fir_valid, fir_d, frm_ready,
        input  frm_valid, frm_data, frm_bank, ovf
    );
endinterface

// File: rtl/fir_frame_buffer.sv
// fir_frame_buffer: packs the FIR sample stream into N-sample frames using a
// ping-pong pair of register banks. One bank fills while the other is offered
// to the FFT stage. A sample that arrives while both banks are full is dropped,
// and the sticky ovf flag records the loss.
//
// Optional build macro FIR_FRAME_DROP_CNT_EN adds a saturating 8-bit drop_cnt
// output. With the macro defined, ovf is drop_cnt != 0.
module fir_frame_buffer #(
    parameter int N  = 16,
    parameter int DW = 16
) (
    input  logic                CLK,
    input  logic                RST,
    fir_frame_buffer_if.slave   bus
`ifdef FIR_FRAME_DROP_CNT_EN
    ,
    output logic [7:0]          drop_cnt
`endif
);
    localparam int WCW = $clog2(N);
    localparam logic [WCW-1:0] WC_LAST = WCW'(N - 1);

    logic [DW-1:0]  mem [2][N];
    logic           wb;        // bank being filled
    logic           rb;        // bank being presented; always trails wb
    logic [WCW-1:0] wc;        // next slot in bank wb
    logic [1:0]     full;      // per-bank "complete frame held" flags

    logic wr_en;
    logic wr_last;
    logic drop;
    logic rd_en;

    // Write/drop/read decisions, all taken from pre-edge state
    always_comb begin
        wr_en   = bus.fir_valid & ~full[wb];
        wr_last = wr_en & (wc == WC_LAST);
        drop    = bus.fir_valid & full[wb];
        rd_en   = full[rb] & bus.frm_ready;
    end

    // Sample storage. Stored bit-exact; reset clears every slot.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int b = 0; b < 2; b++) begin
                for (int k = 0; k < N; k++) begin
                    mem[b][k] <= '0;
                end
            end
        end else if (wr_en) begin
            mem[wb][wc] <= bus.fir_d;
        end
    end

    // Write pointer: advance the slot, and switch bank after the last slot
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wb <= 1'b0;
            wc <= '0;
        end else if (wr_en) begin
            if (wr_last) begin
                wb <= ~wb;
                wc <= '0;
            end else begin
                wc <= wc + 1'b1;
            end
        end
    end

    // Read pointer: switch to the other bank after each frame transfer
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rb <= 1'b0;
        end else if (rd_en) begin
            rb <= ~rb;
        end
    end

    // Full flags, per bank. A fill and a drain never target the same bank in one
    // cycle: a fill needs full[wb]=0 and a drain needs full[rb]=1.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            full <= 2'b00;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (wr_last && (wb == 1'(b))) begin
                    full[b] <= 1'b1;
                end else if (rd_en && (rb == 1'(b))) begin
                    full[b] <= 1'b0;
                end
            end
        end
    end

    // Frame presentation: mux the read bank onto the flat bus, oldest sample at k=0
    always_comb begin
        bus.frm_data = '0;
        for (int k = 0; k < N; k++) begin
            bus.frm_data[k*DW +: DW] = mem[rb][k];
        end
    end

    assign bus.frm_valid = full[rb];
    assign bus.frm_bank  = rb;

`ifdef FIR_FRAME_DROP_CNT_EN
    // Saturating count of dropped samples
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            drop_cnt <= 8'd0;
        end else if (drop && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

    assign bus.ovf = (drop_cnt != 8'd0);
`else
    logic ovf_q;

    // Sticky overflow: set on the first dropped sample, cleared only by reset
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ovf_q <= 1'b0;
        end else if (drop) begin
            ovf_q <= 1'b1;
        end
    end

    assign bus.ovf = ovf_q;
`endif

endmodule
